// File: rtl/mem_pkg.sv
// Shared constants, port ids and the address range check for the memory arbiter.
package mem_pkg;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 19;
  localparam int MEM_DEPTH = 262144;

  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_id_t;

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/mem_arb_prio.sv
// Data-first grant with a starvation counter that forces a fetch grant after
// STARVE_LIMIT consecutive data grants.
module mem_arb_prio
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_valid,
  input  logic       d_valid,
  output logic [1:0] grant
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starv_cnt;
  logic          starved;

  always_comb begin
    grant   = '0;
    starved = (starv_cnt == LIM);
    if (!rst) begin
      if (if_valid && (!d_valid || starved)) grant[PORT_IF] = 1'b1;
      else if (d_valid)                       grant[PORT_D]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               starv_cnt <= '0;
    else if (!if_valid || grant[PORT_IF])  starv_cnt <= '0;
    else if (grant[PORT_D] && !starved)    starv_cnt <= starv_cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Merges fetch and data request ports onto the single RAM port, range-checks
// addresses and routes the 1-cycle RAM response back to the issuing port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = mem_pkg::ADDR_W,
  parameter int DATA_W       = mem_pkg::DATA_W,
  parameter int MEM_DEPTH    = mem_pkg::MEM_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_rdata,
  output logic              if_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  output logic              d_resp_err,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [1:0]        grant;
  logic              acc, sel_d, ok;
  logic [ADDR_W-1:0] req_addr;
  logic              pend_valid, pend_err;
  port_id_t          pend_port;
  logic              if_hit, d_hit;
  logic [DATA_W-1:0] rdata_q;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .grant    (grant)
  );

  assign if_req_ready = grant[PORT_IF];
  assign d_req_ready  = grant[PORT_D];
  assign acc          = |grant;
  assign sel_d        = grant[PORT_D];
  assign req_addr     = sel_d ? d_req_addr : if_req_addr;
  assign ok           = in_range(32'(req_addr), 32'(MEM_DEPTH));

  // Out-of-range requests still consume the grant but never reach the RAM.
  assign mem_valid = acc && ok;
  assign mem_write = mem_valid && sel_d && d_req_write;
  assign mem_addr  = acc ? req_addr : '0;
  assign mem_wdata = (acc && sel_d) ? d_req_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_port  <= PORT_IF;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= acc;
      pend_port  <= sel_d ? PORT_D : PORT_IF;
      pend_err   <= acc && !ok;
    end
  end

  assign if_hit  = pend_valid && (pend_port == PORT_IF);
  assign d_hit   = pend_valid && (pend_port == PORT_D);
  assign rdata_q = pend_err ? '0 : mem_rdata;

  assign if_resp_valid = if_hit;
  assign if_resp_err   = if_hit && pend_err;
  assign if_resp_rdata = if_hit ? rdata_q : '0;
  assign d_resp_valid  = d_hit;
  assign d_resp_err    = d_hit && pend_err;
  assign d_resp_rdata  = d_hit ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Vector table plus hand sequences; expected responses queued on acceptance.
module tb_mem_arbiter;
  localparam int AW = 19;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_valid = 1'b0;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_resp_valid;
  logic [DW-1:0] if_resp_rdata;
  logic          if_resp_err;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic          d_req_write = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic [DW-1:0] d_req_wdata = '0;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_rdata;
  logic          d_resp_err;
  logic          mem_valid, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: read-first, one cycle latency, unwritten words read as 0.
  logic [DW-1:0] ram [int];
  always @(posedge clk) begin
    if (mem_valid) begin
      mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
      if (mem_write) ram[int'(mem_addr)] = mem_wdata;
    end
  end

  typedef struct {
    bit            is_d;
    bit            err;
    logic [DW-1:0] rdata;
  } resp_t;

  typedef struct {
    string         nm;
    bit            ifv;
    logic [AW-1:0] ifa;
    bit            dv;
    bit            dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dwd;
    bit            e_if;
    bit            e_d;
  } vec_t;

  resp_t         sbq[$];
  logic [DW-1:0] shadow [int];
  int            nt = 0;
  int            nf = 0;
  int            max_starv = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input bit r, input bit ifv, input logic [AW-1:0] ifa,
                      input bit dv, input bit dw, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd, input bit e_if, input bit e_d);
    resp_t         e;
    bit            e_ifv, e_dv, e_err, inr, e_mw;
    logic [DW-1:0] e_rd;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    rst = r; if_req_valid = ifv; if_req_addr = ifa;
    d_req_valid = dv; d_req_write = dw; d_req_addr = da; d_req_wdata = dwd;
    #1;
    e_ifv = 0; e_dv = 0; e_err = 0; e_rd = '0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      e_ifv = !e.is_d; e_dv = e.is_d; e_err = e.err; e_rd = e.rdata;
    end
    chk({nm, " if_resp_valid"}, 32'(if_resp_valid), 32'(e_ifv));
    chk({nm, " d_resp_valid"}, 32'(d_resp_valid), 32'(e_dv));
    chk({nm, " if_resp_err"}, 32'(if_resp_err), 32'(e_ifv && e_err));
    chk({nm, " d_resp_err"}, 32'(d_resp_err), 32'(e_dv && e_err));
    chk({nm, " if_resp_rdata"}, 32'(if_resp_rdata), e_ifv ? 32'(e_rd) : 32'd0);
    chk({nm, " d_resp_rdata"}, 32'(d_resp_rdata), e_dv ? 32'(e_rd) : 32'd0);
    chk({nm, " if_req_ready"}, 32'(if_req_ready), 32'(e_if));
    chk({nm, " d_req_ready"}, 32'(d_req_ready), 32'(e_d));
    a    = e_d ? da : ifa;
    inr  = (e_if || e_d) && (int'(a) < 262144);
    e_mw = inr && e_d && dw;
    chk({nm, " mem_valid"}, 32'(mem_valid), 32'(inr));
    chk({nm, " mem_write"}, 32'(mem_write), 32'(e_mw));
    if (inr) chk({nm, " mem_addr"}, 32'(mem_addr), 32'(a));
    if (e_mw) chk({nm, " mem_wdata"}, 32'(mem_wdata), 32'(dwd));
    if (r) begin
      chk({nm, " mem_addr_rst"}, 32'(mem_addr), 32'd0);
      chk({nm, " mem_wdata_rst"}, 32'(mem_wdata), 32'd0);
    end
    if (e_if || e_d) begin
      e.is_d  = e_d;
      e.err   = !inr;
      e.rdata = (inr && shadow.exists(int'(a))) ? shadow[int'(a)] : '0;
      sbq.push_back(e);
      if (e_mw) shadow[int'(a)] = dwd;
    end
    if (int'(dut.u_prio.starv_cnt) > max_starv) max_starv = int'(dut.u_prio.starv_cnt);
  endtask

  initial begin
    vec_t  vt[12];
    string pat;
    bit    gi;
    vt[0]  = '{"idle",     0, 19'h0,     0, 0, 19'h0,     19'h0,     0, 0};
    vt[1]  = '{"st_seed",  0, 19'h0,     1, 1, 19'h00010, 19'h1ABCD, 0, 1};
    vt[2]  = '{"ld_10",    0, 19'h0,     1, 0, 19'h00010, 19'h0,     0, 1};
    vt[3]  = '{"st_top",   0, 19'h0,     1, 1, 19'h3FFFF, 19'h12345, 0, 1};
    vt[4]  = '{"ld_top",   0, 19'h0,     1, 0, 19'h3FFFF, 19'h0,     0, 1};
    vt[5]  = '{"if_oor",   1, 19'h40000, 0, 0, 19'h0,     19'h0,     1, 0};
    vt[6]  = '{"if_ok",    1, 19'h00010, 0, 0, 19'h0,     19'h0,     1, 0};
    vt[7]  = '{"d_oor",    0, 19'h0,     1, 0, 19'h7FFFF, 19'h0,     0, 1};
    vt[8]  = '{"st_oor",   0, 19'h0,     1, 1, 19'h40001, 19'h7FFFF, 0, 1};
    vt[9]  = '{"both",     1, 19'h3FFFF, 1, 0, 19'h00010, 19'h0,     0, 1};
    vt[10] = '{"if_alone", 1, 19'h3FFFF, 0, 0, 19'h0,     19'h0,     1, 0};
    vt[11] = '{"idle2",    0, 19'h0,     0, 0, 19'h0,     19'h0,     0, 0};

    step("rst", 1, 0, 19'h0, 0, 0, 19'h0, 19'h0, 0, 0);
    step("rst2", 1, 1, 19'h10, 1, 0, 19'h10, 19'h0, 0, 0);
    chk("starv_after_rst", 32'(dut.u_prio.starv_cnt), 32'd0);

    foreach (vt[i])
      step(vt[i].nm, 0, vt[i].ifv, vt[i].ifa, vt[i].dv, vt[i].dw, vt[i].da, vt[i].dwd,
           vt[i].e_if, vt[i].e_d);

    // Both ports requesting for 12 cycles: data wins four times, then fetch.
    pat = "ddddiddddidd";
    for (int k = 0; k < 12; k++) begin
      gi = (pat[k] == "i");
      step($sformatf("cont%0d", k), 0, 1, 19'(19'h300 + k), 1, !k[0],
           19'(19'h300 + (k & ~1)), 19'(19'h1000 + k), gi, !gi);
    end
    step("cont_idle", 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 0, 0);

    // Reset with a load response in flight and the starvation counter non-zero.
    step("rs_both", 0, 1, 19'h10, 1, 0, 19'h3FFFF, 19'h0, 0, 1);
    step("rs_ld",   0, 1, 19'h10, 1, 0, 19'h00010, 19'h0, 0, 1);
    step("rs_on",   1, 1, 19'h10, 1, 0, 19'h00010, 19'h0, 0, 0);
    step("rs_hold", 1, 1, 19'h10, 1, 1, 19'h00020, 19'h5, 0, 0);
    chk("starv_rst_mid", 32'(dut.u_prio.starv_cnt), 32'd0);
    step("rs_off",  0, 0, 19'h0,  0, 0, 19'h0,     19'h0, 0, 0);
    step("rs_post", 0, 1, 19'h3FFFF, 0, 0, 19'h0,  19'h0, 1, 0);
    step("rs_end",  0, 0, 19'h0,  0, 0, 19'h0,     19'h0, 0, 0);

    chk("starv_max_le_4", 32'(max_starv <= 4), 32'd1);
    chk("starv_max_hit_4", 32'(max_starv), 32'd4);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter placed directly upstream of the on-chip word-addressed RAM. It merges the pipeline's instruction-fetch port (read-only) and its load/store data port into the RAM's single-request interface. It also range-checks addresses and routes each one-cycle-latency RAM response back to the requester that issued it. Data has priority over fetch, with a starvation guard so that fetch always makes progress.

## Interface
Parameters:
- ADDR_W, 19, word-address width
- DATA_W, 19, word width
- MEM_DEPTH, 262144, number of implemented words; an address ≥ MEM_DEPTH is out of range
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits (legal range ≥ 1)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch word address
- if_resp_valid  out  1  fetch response pulse
- if_resp_rdata  out  DATA_W  fetch read data
- if_resp_err  out  1  fetch address was out of range
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_write  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  data word address
- d_req_wdata  in  DATA_W  store data
- d_resp_valid  out  1  data response pulse (loads and stores)
- d_resp_rdata  out  DATA_W  load data
- d_resp_err  out  1  data address was out of range
- mem_valid  out  1  RAM enable
- mem_write  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_valid

## Operation
- Acceptance: a request is accepted in a cycle where both valid and ready are high. At most one request is accepted per cycle.
- Grant: d wins by default. if wins when d_req_valid=0, or when the starvation count starv_cnt == STARVE_LIMIT. The ready signal is high only for the winning port.
- starv_cnt behaviour:
  - Increments when d is granted while if_req_valid=1.
  - Clears when if is granted or when if_req_valid=0.
  - Saturates at STARVE_LIMIT.
- In-range accepted request: drive mem_valid=1 and pass addr/write/wdata through combinationally. mem_write is always 0 for if.
- Out-of-range accepted request (addr ≥ MEM_DEPTH):
  - mem_valid stays 0 and the RAM is not touched.
  - The request is still accepted and still consumes that cycle's grant.
- Response registers: pend_valid, pend_port, pend_err are captured on acceptance. In the next cycle exactly one resp_valid pulses, on the port recorded in pend_port.
- Response data:
  - resp_rdata = mem_rdata when pend_err=0, and 0 when pend_err=1.
  - The rdata bus of the non-responding port is 0.
  - On a store, d_resp_valid acts as the write acknowledgement. d_resp_rdata then carries the RAM's pre-write contents, and requesters ignore it.
- Responses have no backpressure: requesters must sink them in the pulse cycle.

## Timing
- Request-to-response latency is exactly 1 cycle. Throughput is 1 request per cycle, and back-to-back requests from either port are accepted with no bubbles.
- Simultaneous requests: with both valid every cycle and STARVE_LIMIT=4, the grant sequence is d,d,d,d,if,d,d,d,d,if,…
- During rst=1:
  - if_req_ready, d_req_ready and mem_valid are forced to 0, and nothing is accepted.
  - mem_write=0; mem_addr and mem_wdata are 0.
- Reset values, from the cycle after rst is sampled high:
  - resp_valid, resp_err and resp_rdata on both ports are 0.
  - pend_valid = 0 and starv_cnt = 0.
- Reset mid-operation: a response pending at the reset edge is dropped, so no resp_valid appears after reset.
- Address boundary: MEM_DEPTH-1 = 0x3FFFF is in range. 0x40000 and above (ADDR_W=19) return err.

## Structure
- Shared package mem_pkg holds:
  - ADDR_W, DATA_W, MEM_DEPTH
  - the port-id enum port_id_t {PORT_IF, PORT_D}
  - the in-range check function
- Sub-module mem_arb_prio: the grant logic plus starv_cnt. Inputs: both valids and rst. Outputs: one-hot grant. The top level instantiates it once and keeps the request mux, range check and response registers.

## Test plan
- Single load: d load at 0x00010, with RAM word = 0x1ABCD → d_req_ready same cycle, mem_valid=1, next cycle d_resp_valid=1, d_resp_rdata=0x1ABCD, err=0, if_resp_valid=0.
- Store then load: store 0x12345 to 0x3FFFF, then load 0x3FFFF on the next cycle → store ack, then rdata=0x12345, both 1 cycle after acceptance, no bubble.
- Out of range: fetch 0x40000 → mem_valid=0, next cycle if_resp_valid=1, if_resp_err=1, if_resp_rdata=0.
- Contention: both ports valid for 12 cycles, STARVE_LIMIT=4 → grants d×4, if, d×4, if, d×2; starv_cnt never exceeds 4; every grant is answered by exactly one response on the correct port.
- Reset mid-flight: accept a d load, assert rst on the next edge → no d_resp_valid after reset, all readies 0 while rst=1, starv_cnt=0 afterwards.
